// File: rtl/imem_loader.sv
// imem_loader: receives a big-endian program image over a byte-wide
// valid/ready link and writes 16-bit words into instruction memory.
// The CPU core is held stalled until a load completes successfully.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_WORD_HI,
        S_WORD_LO,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Number of words that fit between BASE_ADDR and the top of memory.
    localparam logic [31:0]       CAP  = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   wl_q, wl_d;

    // Next-state and output decode; outputs depend on state only.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wl_d     = wl_q;
        rx_ready = 1'b0;
        imem_we  = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    len_d  = {len_q[15:8], rx_data};
                    wl_d   = '0;
                    addr_d = BASE;
                    // Rejecting oversize images up front means the write
                    // address can never wrap.
                    if (len_d == 16'd0)
                        state_d = S_DONE;
                    else if ({16'd0, len_d} > CAP)
                        state_d = S_ERR;
                    else
                        state_d = S_WORD_HI;
                end
            end
            S_WORD_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    wdata_d = {rx_data, wdata_q[7:0]};
                    state_d = S_WORD_LO;
                end
            end
            S_WORD_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    wdata_d = {wdata_q[15:8], rx_data};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_we = 1'b1;
                wl_d    = wl_q + 1'b1;
                // On the last word the address stays on the final location.
                if (32'(wl_q) + 32'd1 == 32'(len_q)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_WORD_HI;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_d = S_LEN_HI;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= BASE;
            wdata_q <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wl_q    <= wl_d;
        end
    end

    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (8-bit and 4-bit address) share the
// byte stream; sel picks the one under test. Writes are captured into a
// queue and compared against the image the bench generated.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset, sel, start, rxv;
    logic [7:0] rxd;
    always #5 clk = ~clk;

    logic        rdy_a, we_a, hold_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [15:0] wd_a;
    logic [8:0]  wl_a;
    logic        rdy_b, we_b, hold_b, done_b, err_b;
    logic [3:0]  addr_b;
    logic [15:0] wd_b;
    logic [4:0]  wl_b;
    logic        start_a, rxv_a, start_b, rxv_b;

    assign start_a = start & ~sel;
    assign rxv_a   = rxv & ~sel;
    assign start_b = start & sel;
    assign rxv_b   = rxv & sel;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .rx_data(rxd), .rx_valid(rxv_a),
        .rx_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
        .cpu_hold(hold_a), .done(done_a), .error(err_a), .words_loaded(wl_a));

    imem_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .rx_data(rxd), .rx_valid(rxv_b),
        .rx_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
        .cpu_hold(hold_b), .done(done_b), .error(err_b), .words_loaded(wl_b));

    logic        cur_rdy, cur_we, cur_hold, cur_done, cur_err;
    logic [15:0] cur_addr, cur_wd, cur_wl;
    assign cur_rdy  = sel ? rdy_b  : rdy_a;
    assign cur_we   = sel ? we_b   : we_a;
    assign cur_hold = sel ? hold_b : hold_a;
    assign cur_done = sel ? done_b : done_a;
    assign cur_err  = sel ? err_b  : err_a;
    assign cur_addr = sel ? {12'd0, addr_b} : {8'd0, addr_a};
    assign cur_wd   = sel ? wd_b : wd_a;
    assign cur_wl   = sel ? {11'd0, wl_b} : {7'd0, wl_a};

    typedef struct { int addr; int data; } wr_t;
    wr_t wr_q[$];
    logic [15:0] img_w[$];
    logic [15:0] img_n;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = -100;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write capture: each write must follow its low byte by one cycle and
    // must never coincide with rx_ready.
    always @(negedge clk) begin
        if (!reset && cur_we) begin
            wr_q.push_back('{int'(cur_addr), int'(cur_wd)});
            chk("we_latency", cyc, last_acc);
            chk("ready_in_write", int'(cur_rdy), 0);
        end
        cyc = cyc + 1;
    end

    // Present one byte after a random gap; start is toggled randomly in
    // the gap to show it is ignored mid-load.
    task automatic send(input logic [7:0] b, input int maxgap);
        int g;
        int t;
        bit rdy;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            @(negedge clk);
            rxv = 1'b0; rxd = 8'($urandom); start = 1'($urandom);
        end
        t = 0;
        forever begin
            @(negedge clk);
            start = 1'b0; rxv = 1'b1; rxd = b; rdy = cur_rdy;
            @(posedge clk);
            if (rdy) begin
                last_acc = cyc;
                break;
            end
            t++;
            if (t > 20) begin
                chk("rx_accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"},  int'(cur_rdy),  0);
        chk({tag, "_we"},   int'(cur_we),   0);
        chk({tag, "_addr"}, int'(cur_addr), 0);
        chk({tag, "_wd"},   int'(cur_wd),   0);
        chk({tag, "_hold"}, int'(cur_hold), 1);
        chk({tag, "_done"}, int'(cur_done), 0);
        chk({tag, "_err"},  int'(cur_err),  0);
        chk({tag, "_wl"},   int'(cur_wl),   0);
    endtask

    // Full load of the image in img_n/img_w; expected writes come from the
    // image itself, final status from the caller's expectations.
    task automatic run_load(input int s, input int maxgap, input bit e_err,
                            input int e_wl, input int e_addr);
        int cap;
        bit oversize;
        int t;
        int nexp;
        sel = s[0];
        wr_q.delete();
        cap = s ? 16 : 256;
        oversize = int'(img_n) > cap;
        @(negedge clk);
        start = 1'b1; rxv = 1'b0;
        send(img_n[15:8], maxgap);
        send(img_n[7:0], maxgap);
        if (!oversize)
            for (int i = 0; i < int'(img_n); i++) begin
                send(img_w[i][15:8], maxgap);
                send(img_w[i][7:0], maxgap);
            end
        @(negedge clk);
        rxv = 1'b0; start = 1'b0;
        t = 0;
        while (!(cur_done || cur_err) && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("end_reached", int'(t < 10), 1);
        chk("done",  int'(cur_done), int'(!e_err));
        chk("error", int'(cur_err),  int'(e_err));
        chk("hold",  int'(cur_hold), int'(e_err));
        chk("rdy_idle", int'(cur_rdy), 0);
        chk("words_loaded", int'(cur_wl), e_wl);
        chk("final_addr", int'(cur_addr), e_addr);
        nexp = oversize ? 0 : int'(img_n);
        chk("write_count", wr_q.size(), nexp);
        for (int i = 0; i < nexp && i < wr_q.size(); i++) begin
            chk("wr_addr", wr_q[i].addr, i);
            chk("wr_data", wr_q[i].data, int'(img_w[i]));
        end
    endtask

    typedef struct {
        int s; int n; int maxgap; bit e_err; int e_wl; int e_addr;
    } case_t;

    case_t tbl[10];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0,   0, 0, 1'b0,   0,   0};
        tbl[1] = '{0, 257, 0, 1'b1,   0,   0};
        tbl[2] = '{0,   1, 0, 1'b0,   1,   0};
        tbl[3] = '{0,   4, 3, 1'b0,   4,   3};
        tbl[4] = '{0,   6, 2, 1'b0,   6,   5};
        tbl[5] = '{1,  16, 0, 1'b0,  16,  15};
        tbl[6] = '{1,  17, 1, 1'b1,   0,   0};
        tbl[7] = '{1,  16, 2, 1'b0,  16,  15};
        tbl[8] = '{0, 256, 0, 1'b0, 256, 255};
        tbl[9] = '{0,   3, 1, 1'b0,   3,   2};

        reset = 1'b1; sel = 1'b0; start = 1'b0; rxv = 1'b0; rxd = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset("rst_a");
        sel = 1'b1;
        #1;
        chk_reset("rst_b");
        sel = 1'b0;

        // Reset and start together: reset wins, loader stays idle.
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_rdy", int'(cur_rdy), 0);
        chk("rst_start_hold", int'(cur_hold), 1);

        // Basic two-word image.
        img_n = 16'd2; img_w = '{16'h1234, 16'hABCD};
        run_load(0, 0, 1'b0, 2, 1);

        // Oversize header, then a good load clears the error.
        img_n = 16'd257; img_w.delete();
        run_load(0, 0, 1'b1, 0, 0);
        img_n = 16'd1; img_w = '{16'h55AA};
        run_load(0, 0, 1'b0, 1, 0);

        // Reset after the first word's high byte.
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'hBE, 0);
        @(negedge clk);
        rxv = 1'b0; start = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk_reset("midload");
        reset = 1'b0;
        img_n = 16'd1; img_w = '{16'hBEEF};
        run_load(0, 0, 1'b0, 1, 0);

        // Randomized images from the table.
        for (int k = 0; k < 10; k++) begin
            img_n = 16'(tbl[k].n);
            img_w.delete();
            for (int i = 0; i < tbl[k].n; i++) img_w.push_back(16'($urandom));
            run_load(tbl[k].s, tbl[k].maxgap, tbl[k].e_err, tbl[k].e_wl, tbl[k].e_addr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the CPU's instruction memory: streams a program image in byte-wide over a valid/ready link and writes 16-bit instruction words into instruction memory.
- Holds the CPU core stalled while loading, then releases it.
- Sits between the host/UART byte source and the instruction memory write port, in parallel with the core's fetch path.

Parameters:
- ADDR_W, 8, instruction memory address width; memory depth = 2**ADDR_W words.
- BASE_ADDR, 0, first instruction memory address written.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE, DONE or ERR.
- rx_data  input  8  incoming image byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  instruction memory write address.
- imem_wdata  output  16  instruction word to write.
- cpu_hold  output  1  stalls/holds the CPU core while high.
- done  output  1  load completed successfully.
- error  output  1  header word count exceeds memory depth.
- words_loaded  output  ADDR_W+1  number of words written in the current load.

Behaviour:
- Image format is big-endian throughout: LEN_HI, LEN_LO (16-bit word count N), then N words, each sent as high byte then low byte.
- A byte transfers on any cycle with rx_valid=1 and rx_ready=1; nothing transfers otherwise. rx_data is ignored when no transfer occurs.
- Reset values: state=IDLE, rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0.
- IDLE: rx_ready=0, cpu_hold=1. start=1 -> LEN_HI.
- LEN_HI: rx_ready=1. On transfer, latch byte into N[15:8] -> LEN_LO.
- LEN_LO: rx_ready=1. On transfer, latch N[7:0], clear words_loaded, set imem_addr=BASE_ADDR. Next state:
  - N==0 -> DONE
  - N > 2**ADDR_W - BASE_ADDR -> ERR
  - otherwise -> WORD_HI
- WORD_HI: rx_ready=1. On transfer, latch imem_wdata[15:8] -> WORD_LO.
- WORD_LO: rx_ready=1. On transfer, latch imem_wdata[7:0] -> WRITE.
- WRITE: rx_ready=0; imem_we=1 for exactly this cycle with stable imem_addr/imem_wdata. words_loaded increments at the end of the cycle. If words_loaded+1==N -> DONE; else imem_addr increments and state -> WORD_HI.
  - Latency: the write strobe appears the cycle after the low byte is accepted.
  - Maximum throughput is one word per 3 cycles.
- DONE: done=1, cpu_hold=0, rx_ready=0. imem_addr holds the last written address; words_loaded holds N. start=1 -> LEN_HI, with done=0 and cpu_hold=1 from the next cycle.
- ERR: error=1, cpu_hold=1, rx_ready=0, no writes. start=1 -> LEN_HI with error cleared.
- imem_we is never asserted outside WRITE. imem_addr never exceeds 2**ADDR_W-1; the ERR check guarantees no wrap-around.
- start is ignored in LEN_*, WORD_* and WRITE states. A load cannot be restarted mid-stream except by reset.
- rx_valid gaps (stalls) of any length in any receive state preserve all state.
- Reset mid-load returns all outputs to reset values on the next edge. Words already written remain in memory; done stays 0 and cpu_hold stays 1.
- Simultaneous reset and start: reset wins.

Test Plan:
- Basic load, no stalls: reset, start, bytes 00 02 12 34 AB CD -> writes (addr0, 0x1234) and (addr1, 0xABCD), each imem_we a single cycle after its low byte. Then done=1, cpu_hold=0, words_loaded=2.
- Zero-length image: bytes 00 00 -> DONE the cycle after LEN_LO, no imem_we pulse, done=1, words_loaded=0.
- Oversize header, ADDR_W=8, BASE_ADDR=0: bytes 01 01 (N=257) -> error=1, cpu_hold=1, no writes, rx_ready=0. Then start with 00 01 55 AA -> error clears, write (0, 0x55AA), done=1.
- Backpressure and gaps: random rx_valid deassertion between and within words for N=4 -> same four writes at addresses 0..3 with correct data. rx_ready must be 0 in every WRITE cycle, and a byte presented then is not consumed.
- Full memory, ADDR_W=4: N=16 -> last write at addr 15, done=1, words_loaded=16, no address wrap.
- Reset mid-load: assert reset after the first word's high byte -> all outputs return to reset values next cycle. A following full load of 00 01 BE EF writes (0, 0xBEEF) correctly.
